// File: rtl/tb_uart_pkg.sv
// tb_uart_pkg: shared types and constants for the tb_uart 8N1 UART.
//   - tx_state_e / rx_state_e : transmitter and receiver FSM states
//   - DATA_BITS, START_BIT, STOP_BIT : frame constants
//   - CNT_W : width of the per-bit cycle counters (covers CLKS_PER_BIT up to 65535)
package tb_uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop,
        TxClear
    } tx_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/tb_uart_if.sv
// tb_uart_if: serial lines plus the byte-level TX/RX handshake of tb_uart.
//   slave  : UART side (receives ser_rx/tx_start/tx_data, drives the rest)
//   master : user side (drives ser_rx/tx_start/tx_data, observes the rest)
interface tb_uart_if;

    logic       ser_rx;
    logic       ser_tx;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    modport slave (
        input  ser_rx, tx_start, tx_data,
        output ser_tx, tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err
    );

    modport master (
        output ser_rx, tx_start, tx_data,
        input  ser_tx, tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err
    );

endinterface

// File: rtl/tb_uart_rx.sv
// tb_uart_rx: 8N1 receiver with a 2-flop input synchronizer and mid-bit sampling.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   i_ser_rx         : asynchronous serial input, idle high
//   o_rx_data        : last correctly framed byte
//   o_rx_valid       : one-cycle pulse when o_rx_data updates
//   o_rx_frame_err   : one-cycle pulse when the stop bit samples low
// Optional: define TB_UART_RX_PRINT_EN to print each received byte and framing errors.
module tb_uart_rx
    import tb_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 347
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_ser_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_frame_err
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       r_sync;
    logic             r_rx_prev;
    rx_state_e        r_rx_state;
    rx_state_e        w_rx_state_next;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_err;

    logic w_rx;
    logic w_fall;
    logic w_half;
    logic w_bit_done;
    logic w_last_bit;
    logic w_valid_next;
    logic w_err_next;

    assign w_rx       = r_sync[1];
    assign w_fall     = r_rx_prev & ~w_rx;
    assign w_half     = (r_rx_cnt == HALF_LAST);
    assign w_bit_done = (r_rx_cnt == BIT_LAST);
    assign w_last_bit = (r_rx_bit == 3'(DATA_BITS - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state <= RxIdle;
        end else begin
            r_rx_state <= w_rx_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_rx_state_next = r_rx_state;
        unique case (r_rx_state)
            RxIdle:  if (w_fall) w_rx_state_next = RxStart;
            // A start bit that is high again at mid-bit was a glitch.
            RxStart: if (w_half) w_rx_state_next = (w_rx == START_BIT) ? RxData : RxIdle;
            RxData:  if (w_bit_done && w_last_bit) w_rx_state_next = RxStop;
            RxStop:  if (w_bit_done) w_rx_state_next = RxIdle;
            default: w_rx_state_next = RxIdle;
        endcase
    end

    // Output decode: stop-bit verdict
    always_comb begin
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        if (r_rx_state == RxStop && w_bit_done) begin
            w_valid_next = (w_rx == STOP_BIT);
            w_err_next   = (w_rx != STOP_BIT);
        end
    end

    // Synchronizer, counters and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync     <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_ser_rx};
            r_rx_prev  <= w_rx;
            r_rx_valid <= w_valid_next;
            r_rx_err   <= w_err_next;
            if (w_valid_next) begin
                r_rx_data <= r_rx_shift;
            end
            unique case (r_rx_state)
                RxIdle: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                end
                RxStart: r_rx_cnt <= w_half ? '0 : r_rx_cnt + 1'b1;
                RxData: begin
                    if (w_bit_done) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};  // LSB arrives first
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RxStop:  r_rx_cnt <= w_bit_done ? '0 : r_rx_cnt + 1'b1;
                default: r_rx_cnt <= '0;
            endcase
        end
    end

`ifdef TB_UART_RX_PRINT_EN
    always_ff @(posedge clock) begin
        if (r_rx_valid) begin
            $display("tb_uart_rx: received %0d (0x%02h)", r_rx_data, r_rx_data);
        end
        if (r_rx_err) begin
            $display("tb_uart_rx: framing error");
        end
    end
`else
    // Silent build: no simulation output.
`endif

    assign o_rx_data      = r_rx_data;
    assign o_rx_valid     = r_rx_valid;
    assign o_rx_frame_err = r_rx_err;

endmodule

// File: rtl/tb_uart.sv
// tb_uart: 8N1 UART, transmitter implemented here, receiver in tb_uart_rx.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : ser_rx/ser_tx serial lines, tx_start/tx_data/tx_busy/tx_clear_req
//                  transmit handshake, rx_data/rx_valid/rx_frame_err receive outputs
// Parameter CLKS_PER_BIT: clock cycles per serial bit (4..65535).
// Optional: TB_UART_RX_PRINT_EN enables receive-side printing inside tb_uart_rx.
module tb_uart
    import tb_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 347
) (
    input  logic   clock,
    input  logic   reset,
    tb_uart_if.slave bus
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        r_tx_state;
    tx_state_e        w_tx_state_next;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;

    logic w_bit_done;
    logic w_last_bit;
    logic w_ser_tx;
    logic w_tx_busy;
    logic w_tx_clear_req;

    assign w_bit_done = (r_tx_cnt == BIT_LAST);
    assign w_last_bit = (r_tx_bit == 3'(DATA_BITS - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state <= TxIdle;
        end else begin
            r_tx_state <= w_tx_state_next;
        end
    end

    // Next-state logic; tx_start is a level, so CLEAR waits for it to drop
    // to guarantee one frame per request.
    always_comb begin
        w_tx_state_next = r_tx_state;
        unique case (r_tx_state)
            TxIdle:  if (bus.tx_start) w_tx_state_next = TxStart;
            TxStart: if (w_bit_done) w_tx_state_next = TxData;
            TxData:  if (w_bit_done && w_last_bit) w_tx_state_next = TxStop;
            TxStop:  if (w_bit_done) w_tx_state_next = TxClear;
            TxClear: if (!bus.tx_start) w_tx_state_next = TxIdle;
            default: w_tx_state_next = TxIdle;
        endcase
    end

    // Output decode
    always_comb begin
        w_ser_tx       = STOP_BIT;
        w_tx_busy      = 1'b0;
        w_tx_clear_req = 1'b0;
        unique case (r_tx_state)
            TxStart: begin
                w_ser_tx  = START_BIT;
                w_tx_busy = 1'b1;
            end
            TxData: begin
                w_ser_tx  = r_tx_shift[0];
                w_tx_busy = 1'b1;
            end
            TxStop:  w_tx_busy      = 1'b1;
            TxClear: w_tx_clear_req = 1'b1;
            default: ;
        endcase
    end

    // Bit timing and data shift; tx_data is only looked at in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            unique case (r_tx_state)
                TxIdle: begin
                    r_tx_cnt <= '0;
                    r_tx_bit <= '0;
                    if (bus.tx_start) begin
                        r_tx_shift <= bus.tx_data;
                    end
                end
                TxStart, TxStop: r_tx_cnt <= w_bit_done ? '0 : r_tx_cnt + 1'b1;
                TxData: begin
                    if (w_bit_done) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= r_tx_bit + 1'b1;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_cnt <= '0;
            endcase
        end
    end

    assign bus.ser_tx       = w_ser_tx;
    assign bus.tx_busy      = w_tx_busy;
    assign bus.tx_clear_req = w_tx_clear_req;

    tb_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock         (clock),
        .reset         (reset),
        .i_ser_rx      (bus.ser_rx),
        .o_rx_data     (bus.rx_data),
        .o_rx_valid    (bus.rx_valid),
        .o_rx_frame_err(bus.rx_frame_err)
    );

endmodule

// File: tb/tb_tb_uart.sv
// tb_tb_uart: directed self-checking bench for tb_uart with CLKS_PER_BIT=4.
// Covers reset state, TX framing, loopback, held tx_start, RX glitch rejection,
// framing error handling and reset in the middle of a TX frame.
module tb_tb_uart;

    localparam int unsigned CLKS = 4;

    logic clock = 1'b0;
    logic reset;
    logic rx_drive;
    logic loopback;

    tb_uart_if bus ();

    assign bus.ser_rx = loopback ? bus.ser_tx : rx_drive;

    tb_uart #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    logic [7:0] rx_log [0:7];

    // Receive monitor: counts pulse cycles so a stretched pulse is noticed.
    always @(posedge clock) begin
        if (!reset) begin
            if (bus.rx_valid) begin
                rx_log[n_valid[2:0]] <= bus.rx_data;
                n_valid <= n_valid + 1;
            end
            if (bus.rx_frame_err) begin
                n_err <= n_err + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame and checks every cycle of it; pat is {stop, d7..d0, start}.
    task automatic tx_frame(input logic [7:0] data, input logic [9:0] pat, input string tag);
        bus.tx_data  = data;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
        bus.tx_data  = ~data;
        for (int i = 0; i < 40; i++) begin
            check({tag, "_ser"}, bus.ser_tx, pat[i / 4]);
            check({tag, "_busy"}, bus.tx_busy, 1);
            tick();
        end
        check({tag, "_busy_end"}, bus.tx_busy, 0);
        check({tag, "_clear"}, bus.tx_clear_req, 1);
        check({tag, "_idle_line"}, bus.ser_tx, 1);
        tick();
        check({tag, "_clear_drop"}, bus.tx_clear_req, 0);
    endtask

    task automatic lb_send(input logic [7:0] data, input string tag);
        int i;
        bus.tx_data  = data;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
        i = 0;
        while (i < 200 && !bus.tx_clear_req) begin
            tick();
            i++;
        end
        check({tag, "_done"}, bus.tx_clear_req, 1);
        repeat (10) tick();
    endtask

    task automatic rx_frame(input logic [7:0] data, input logic stop_bit);
        rx_drive = 1'b0;
        repeat (CLKS) tick();
        for (int b = 0; b < 8; b++) begin
            rx_drive = data[b];
            repeat (CLKS) tick();
        end
        rx_drive = stop_bit;
        repeat (CLKS) tick();
        rx_drive = 1'b1;
        repeat (3 * CLKS) tick();
    endtask

    int v0;
    int e0;
    int busy_cnt;
    int clear_cnt;
    int rises;
    logic prev_busy;

    initial begin
        reset        = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        rx_drive     = 1'b1;
        loopback     = 1'b0;
        repeat (3) tick();
        check("rst_ser_tx", bus.ser_tx, 1);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_clear", bus.tx_clear_req, 0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_frame_err", bus.rx_frame_err, 0);
        reset = 1'b0;
        tick();

        // 0x55 frame: 0,1,0,1,0,1,0,1,0,1
        tx_frame(8'h55, 10'b1_0101_0101_0, "tx55");
        repeat (3) tick();

        // Loopback of 0xA5 then 0x3C
        loopback = 1'b1;
        repeat (2) tick();
        v0 = n_valid;
        e0 = n_err;
        lb_send(8'hA5, "lbA5");
        lb_send(8'h3C, "lb3C");
        check("lb_valid_count", n_valid - v0, 2);
        check("lb_first", rx_log[v0[2:0]], 8'hA5);
        check("lb_second", rx_log[v0[2:0] + 3'd1], 8'h3C);
        check("lb_no_err", n_err - e0, 0);
        check("lb_rx_data", bus.rx_data, 8'h3C);
        loopback = 1'b0;
        repeat (2) tick();

        // tx_start held high for 100 cycles
        busy_cnt  = 0;
        clear_cnt = 0;
        rises     = 0;
        prev_busy = 1'b0;
        bus.tx_data  = 8'h81;
        bus.tx_start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bus.tx_busy) busy_cnt++;
            if (bus.tx_clear_req) clear_cnt++;
            if (bus.tx_busy && !prev_busy) rises++;
            prev_busy = bus.tx_busy;
            if (k == 41) check("hold_clear41", bus.tx_clear_req, 1);
        end
        check("hold_busy_cycles", busy_cnt, 40);
        check("hold_clear_cycles", clear_cnt, 60);
        check("hold_one_frame", rises, 1);
        bus.tx_start = 1'b0;
        tick();
        check("hold_clear_drop", bus.tx_clear_req, 0);
        repeat (5) tick();
        check("hold_no_second", bus.tx_busy, 0);

        // One-cycle low glitch on idle ser_rx
        v0 = n_valid;
        e0 = n_err;
        rx_drive = 1'b0;
        tick();
        rx_drive = 1'b1;
        repeat (20) tick();
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_no_err", n_err - e0, 0);

        // Good frame 0x5A, then 0xFF with a bad stop bit
        v0 = n_valid;
        e0 = n_err;
        rx_frame(8'h5A, 1'b1);
        check("rx5A_valid", n_valid - v0, 1);
        check("rx5A_data", bus.rx_data, 8'h5A);
        check("rx5A_no_err", n_err - e0, 0);
        v0 = n_valid;
        e0 = n_err;
        rx_frame(8'hFF, 1'b0);
        check("ferr_pulse", n_err - e0, 1);
        check("ferr_no_valid", n_valid - v0, 0);
        check("ferr_data_kept", bus.rx_data, 8'h5A);

        // Reset at cycle 15 of a TX frame of 0x00
        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
        repeat (14) tick();
        check("midrst_busy_before", bus.tx_busy, 1);
        check("midrst_ser_before", bus.ser_tx, 0);
        reset = 1'b1;
        tick();
        check("midrst_ser_tx", bus.ser_tx, 1);
        check("midrst_busy", bus.tx_busy, 0);
        check("midrst_clear", bus.tx_clear_req, 0);
        check("midrst_rx_data", bus.rx_data, 8'h00);
        reset = 1'b0;
        tick();
        check("midrst_idle_busy", bus.tx_busy, 0);
        check("midrst_idle_ser", bus.ser_tx, 1);
        tx_frame(8'hC3, 10'b1_1100_0011_0, "txC3");
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_uart.md
TB_UART -- requirements
Module: tb_uart

Interface
- REQ-001 SHALL have parameter CLKS_PER_BIT, default 347, meaning clock cycles per serial bit (115200 baud at 40 MHz); legal range 4..65535.
- REQ-002 SHALL have port clock, input, 1, sole clock; one clock; all logic on its rising edge.
- REQ-003 SHALL have port reset, input, 1, reset; reset is synchronous and active-high.
- REQ-004 SHALL have port ser_rx, input, 1, serial line into the receiver, idle high.
- REQ-005 SHALL have port ser_tx, output, 1, serial line out of the transmitter, idle high.
- REQ-006 SHALL have port tx_start, input, 1, level request to send tx_data.
- REQ-007 SHALL have port tx_data, input, 8, byte to transmit.
- REQ-008 SHALL have port tx_busy, output, 1, high while a frame is on ser_tx.
- REQ-009 SHALL have port tx_clear_req, output, 1, high after a frame completes until tx_start is seen low.
- REQ-010 SHALL have port rx_data, output, 8, last received byte.
- REQ-011 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_data is updated.
- REQ-012 SHALL have port rx_frame_err, output, 1, one-cycle pulse on a bad stop bit.

Function
- REQ-013 SHALL use 8N1 framing, LSB first: start bit 0, 8 data bits, stop bit 1, each CLKS_PER_BIT cycles.
- REQ-014 Transmitter SHALL use states IDLE -> START -> DATA -> STOP -> CLEAR -> IDLE.
- REQ-015 In IDLE with tx_start=1 sampled at cycle N: SHALL latch tx_data, drive ser_tx=0 and tx_busy=1 from cycle N+1.
- REQ-016 SHALL hold each bit exactly CLKS_PER_BIT cycles; frame length 10*CLKS_PER_BIT cycles.
- REQ-017 SHALL deassert tx_busy on the cycle after the stop bit ends, entering CLEAR with tx_clear_req=1 and ser_tx=1.
- REQ-018 In CLEAR: SHALL stay until tx_start=0, then drop tx_clear_req next cycle and return to IDLE; a held tx_start SHALL never produce a second frame.
- REQ-019 SHALL ignore changes to tx_data and tx_start during START/DATA/STOP.
- REQ-020 Receiver SHALL pass ser_rx through a 2-flop synchronizer before any use.
- REQ-021 Receiver states SHALL be IDLE -> START -> DATA -> STOP -> IDLE; a synchronized falling edge in IDLE enters START.
- REQ-022 SHALL sample at mid-bit (CLKS_PER_BIT/2, integer division, after start detect, then every CLKS_PER_BIT).
- REQ-023 If the start sample is 1: SHALL treat the event as a glitch, return to IDLE, no pulses.
- REQ-024 Stop sample 1: SHALL update rx_data and pulse rx_valid for one cycle; stop sample 0: SHALL pulse rx_frame_err, leave rx_data unchanged, no rx_valid.
- REQ-025 Receiver SHALL re-arm in IDLE immediately after the stop sample (back-to-back frames accepted).
- REQ-026 Transmitter and receiver SHALL be independent; simultaneous TX and RX SHALL both operate.

Reset
- REQ-027 reset=1 SHALL force both FSMs to IDLE, clear counters, ser_tx=1, tx_busy=0, tx_clear_req=0, rx_data=0, rx_valid=0, rx_frame_err=0, synchronizer flops=1.
- REQ-028 Reset mid-frame SHALL abort the frame with no pulses; the next cycle after release is IDLE.

Configuration
- REQ-029 With TB_UART_RX_PRINT_EN defined: SHALL $display each received byte (decimal and hex) on every rx_valid pulse and "framing error" on rx_frame_err; without it: SHALL not print; port behaviour SHALL be identical in both cases.

Structure
- REQ-030 Package tb_uart_pkg SHALL hold the TX and RX state enums and the frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1).
- REQ-031 Receiver SHALL be sub-module tb_uart_rx; the transmitter SHALL remain in tb_uart.

Verification (CLKS_PER_BIT=4)
- REQ-032 tx_start=1 with tx_data=0x55: SHALL drive ser_tx 0,1,0,1,0,1,0,1,0,1, 4 cycles each; tx_busy high exactly 40 cycles.
- REQ-033 Loopback ser_tx->ser_rx, send 0xA5 then 0x3C: SHALL give rx_valid twice with rx_data=0xA5 then 0x3C, no rx_frame_err.
- REQ-034 tx_start held high 100 cycles: SHALL send exactly one frame; tx_clear_req=1 from cycle 41 until one cycle after tx_start=0.
- REQ-035 1-cycle low glitch on idle ser_rx: SHALL give no rx_valid and no rx_frame_err.
- REQ-036 Frame 0xFF with stop bit 0: SHALL pulse rx_frame_err once; rx_data keeps its previous value.
- REQ-037 reset asserted at cycle 15 of a TX frame: SHALL give ser_tx=1 and tx_busy=0 on the next cycle; a new tx_start after release SHALL send a full frame.
